// File: rtl/uop_sequencer_pkg.sv
// Shared codes, FSM state type and the instruction decode table for the micro-op sequencer.
package uop_pkg;

  localparam int OPE_W     = 32;
  localparam int SEL_W     = 4;
  localparam int LEN_W     = 4;
  localparam int MAX_STEPS = 3;
  localparam int STEP_W    = 2;

  localparam logic [SEL_W-1:0] REG_ESP = SEL_W'(1);
  localparam logic [SEL_W-1:0] REG_EBP = SEL_W'(2);
  localparam logic [SEL_W-1:0] REG_EAX = SEL_W'(3);
  localparam logic [SEL_W-1:0] REG_EIP = SEL_W'(4);
  localparam logic [SEL_W-1:0] REG_STK = SEL_W'(5);

  localparam logic [SEL_W-1:0] SRC_ESP = SEL_W'(1);
  localparam logic [SEL_W-1:0] SRC_EBP = SEL_W'(2);
  localparam logic [SEL_W-1:0] SRC_EAX = SEL_W'(3);
  localparam logic [SEL_W-1:0] SRC_EIP = SEL_W'(4);
  localparam logic [SEL_W-1:0] SRC_STK = SEL_W'(5);
  localparam logic [SEL_W-1:0] SRC_IMM = SEL_W'(6);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_TRAP} state_t;

  typedef struct packed {
    logic              legal;
    logic [STEP_W-1:0] nsteps;
    logic [LEN_W-1:0]  len;
    logic [SEL_W-1:0]  reg_load;
    logic [SEL_W-1:0]  select;
  } uop_t;

  // Steps past the end of an instruction (and undecodable words) yield zero codes.
  function automatic uop_t uop_decode(input logic [7:0] opcode, input logic [7:0] modrm,
                                      input logic [STEP_W-1:0] step);
    uop_t d;
    logic [2*SEL_W-1:0] s0, s1, s2;
    d  = '0;
    s0 = '0;
    s1 = '0;
    s2 = '0;
    case (opcode)
      8'h55: begin
        d.legal = 1'b1; d.nsteps = STEP_W'(2); d.len = LEN_W'(1);
        s0 = {REG_ESP, SRC_EBP}; s1 = {REG_ESP, SRC_ESP};
      end
      8'h89: begin
        d.legal = 1'b1; d.nsteps = STEP_W'(1); d.len = LEN_W'(2);
        s0 = {REG_EBP, SRC_EBP};
      end
      8'hb8: begin
        d.legal = 1'b1; d.nsteps = STEP_W'(1); d.len = LEN_W'(5);
        s0 = {REG_EAX, SRC_EAX};
      end
      8'h5d: begin
        d.legal = 1'b1; d.nsteps = STEP_W'(2); d.len = LEN_W'(1);
        s0 = {REG_EBP, SRC_EIP}; s1 = {REG_EBP, SRC_EBP};
      end
      8'hc3: begin
        d.legal = 1'b1; d.nsteps = STEP_W'(2); d.len = LEN_W'(1);
        s0 = {REG_EIP, SRC_EIP}; s1 = {REG_EBP, SRC_EBP};
      end
      8'h6a: begin
        d.legal = 1'b1; d.nsteps = STEP_W'(2); d.len = LEN_W'(2);
        s0 = {REG_ESP, SRC_EBP}; s1 = {REG_ESP, SRC_EIP};
      end
      8'he2, 8'he8: begin
        d.legal = 1'b1; d.nsteps = STEP_W'(3); d.len = LEN_W'(5);
        s0 = {REG_ESP, SRC_EBP}; s1 = {REG_ESP, SRC_EAX}; s2 = {REG_EIP, SRC_EBP};
      end
      8'h8b: if (modrm == 8'h45 || modrm == 8'h85) begin
        d.legal = 1'b1; d.nsteps = STEP_W'(2);
        d.len   = (modrm == 8'h45) ? LEN_W'(3) : LEN_W'(6);
        s0 = {REG_STK, SRC_STK}; s1 = {REG_EAX, SRC_IMM};
      end
      8'h83: if (modrm == 8'he8) begin
        d.legal = 1'b1; d.nsteps = STEP_W'(1); d.len = LEN_W'(3);
        s0 = {REG_EAX, SRC_IMM};
      end else if (modrm == 8'hc4) begin
        d.legal = 1'b1; d.nsteps = STEP_W'(1); d.len = LEN_W'(3);
        s0 = {REG_ESP, SRC_EBP};
      end
      default: ;
    endcase
    if (step == STEP_W'(0))      {d.reg_load, d.select} = s0;
    else if (step == STEP_W'(1)) {d.reg_load, d.select} = s1;
    else if (step == STEP_W'(2)) {d.reg_load, d.select} = s2;
    return d;
  endfunction

endpackage

// File: rtl/uop_sequencer_if.sv
// Fetch/datapath-facing bundle of the micro-op sequencer; master drives instructions and stall.
interface uop_sequencer_if;
  import uop_pkg::*;

  logic [OPE_W-1:0]  ope;
  logic              ope_valid;
  logic              ope_ready;
  logic              stall;
  logic              uop_valid;
  logic [SEL_W-1:0]  reg_load;
  logic [SEL_W-1:0]  select;
  logic [STEP_W-1:0] step_idx;
  logic              last_step;
  logic              ope_done;
  logic [LEN_W-1:0]  num_of_ope;
  logic              illegal;

  modport master (
    output ope, ope_valid, stall,
    input  ope_ready, uop_valid, reg_load, select, step_idx, last_step, ope_done, num_of_ope, illegal
  );

  modport slave (
    input  ope, ope_valid, stall,
    output ope_ready, uop_valid, reg_load, select, step_idx, last_step, ope_done, num_of_ope, illegal
  );
endinterface

// File: rtl/uop_sequencer_rom.sv
// Combinational micro-op table lookup: (opcode, modrm, step) -> decode entry.
module uop_rom
  import uop_pkg::*;
(
  input  logic [7:0]        opcode,
  input  logic [7:0]        modrm,
  input  logic [STEP_W-1:0] step,
  output uop_t              entry
);
  assign entry = uop_decode(opcode, modrm, step);
endmodule

// File: rtl/uop_sequencer.sv
// Expands one instruction word into 1..MAX_STEPS micro-ops, one per cycle, honouring stall.
module uop_sequencer
  import uop_pkg::*;
(
  input  logic            clk2,
  input  logic            reset,
  uop_sequencer_if.slave  bus
);

  if (MAX_STEPS < 3) begin : g_bad_steps
    $error("uop_sequencer: MAX_STEPS must be at least 3");
  end

  localparam logic [STEP_W-1:0] STEP0 = '0;

  state_t            state;
  logic [STEP_W-1:0] step;
  logic [7:0]        opc;
  logic [7:0]        mrm;
  logic              vld;
  logic [LEN_W-1:0]  num_q;
  logic              ill_q;

  uop_t cur;
  uop_t nxt;
  logic last;
  logic fire_last;
  logic ready;
  logic xfer;
  logic unused_bits;

  uop_rom u_cur (.opcode(opc), .modrm(mrm), .step(step), .entry(cur));
  uop_rom u_dec (.opcode(bus.ope[OPE_W-1 -: 8]), .modrm(bus.ope[OPE_W-9 -: 8]),
                 .step(STEP0), .entry(nxt));

  assign last      = (step == cur.nsteps - STEP_W'(1));
  assign fire_last = vld && last && !bus.stall && !reset;
  // Completing instruction frees the slot in the same cycle, so a new word loads with no bubble.
  assign ready     = !reset && ((state == ST_IDLE) || fire_last);
  assign xfer      = bus.ope_valid && ready;

  always_ff @(posedge clk2) begin
    if (reset) begin
      state <= ST_IDLE;
      step  <= '0;
      opc   <= '0;
      mrm   <= '0;
      vld   <= 1'b0;
      num_q <= '0;
      ill_q <= 1'b0;
    end else begin
      if (fire_last) num_q <= cur.len;
      case (state)
        ST_IDLE, ST_ISSUE: begin
          if (xfer) begin
            step <= '0;
            if (nxt.legal) begin
              state <= ST_ISSUE;
              vld   <= 1'b1;
              opc   <= bus.ope[OPE_W-1 -: 8];
              mrm   <= bus.ope[OPE_W-9 -: 8];
            end else begin
              state <= ST_TRAP;
              vld   <= 1'b0;
              ill_q <= 1'b1;
            end
          end else if (fire_last) begin
            state <= ST_IDLE;
            vld   <= 1'b0;
            step  <= '0;
          end else if (vld && !bus.stall) begin
            step <= step + STEP_W'(1);
          end
        end
        ST_TRAP: vld <= 1'b0;
        default: begin
          state <= ST_IDLE;
          vld   <= 1'b0;
          step  <= '0;
        end
      endcase
    end
  end

  assign bus.ope_ready  = ready;
  assign bus.uop_valid  = vld;
  assign bus.reg_load   = vld ? cur.reg_load : '0;
  assign bus.select     = vld ? cur.select : '0;
  assign bus.step_idx   = step;
  assign bus.last_step  = vld && last;
  assign bus.ope_done   = fire_last;
  assign bus.num_of_ope = num_q;
  assign bus.illegal    = ill_q;

  assign unused_bits = ^{cur.legal, nxt.nsteps, nxt.len, nxt.reg_load, nxt.select,
                         bus.ope[OPE_W-17:0]};

endmodule
